// File: rtl/i2c_sensor_sequencer_pkg.sv
// Shared definitions for the I2C sensor sequencer slice.
// Contents:
//   seq_state_t  - sequencer FSM states
//   seq_op_t     - kind of transaction issued to the I2C master engine
//   IMU_INIT_*   - default configuration table for the IMU (entry 0 in the LSBs)
//   table_entry  - picks one byte out of a flat table of up to 8 entries
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ARM,
    ST_ACTIVE,
    ST_GAP,
    ST_WAIT_TRIG,
    ST_FAULT
  } seq_state_t;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } seq_op_t;

  // Entry 0 is PWR_MGMT_1 (0x6B) <= 0x00 (wake up), entry 1 is
  // GYRO_CONFIG (0x1B) <= 0x18 (full-scale range).
  localparam int                          IMU_INIT_LEN  = 2;
  localparam logic [IMU_INIT_LEN*8-1:0]   IMU_INIT_REGS = {8'h1B, 8'h6B};
  localparam logic [IMU_INIT_LEN*8-1:0]   IMU_INIT_VALS = {8'h18, 8'h00};

  function automatic logic [7:0] table_entry(input logic [63:0] flat, input logic [3:0] idx);
    return flat[{idx[2:0], 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/i2c_sensor_sequencer_if.sv
// Request interface between the sequencer and the I2C master engine.
// master modport: the sequencer side (drives address/size/enables/write data,
//                 receives read data, per-byte valid, NACK and BUSY).
// slave modport:  the engine side.
interface i2c_sensor_sequencer_if;

  logic [6:0] DEVICE_ADDR;
  logic [7:0] REG_ADDR;
  logic       READ_EN;
  logic [7:0] READ_SIZE;
  logic       WRITE_EN;
  logic [7:0] WRITE_DATA;
  logic [7:0] READ_DATA;
  logic       READ_VALID;
  logic       NACK;
  logic       BUSY;

  modport master (
    output DEVICE_ADDR, REG_ADDR, READ_EN, READ_SIZE, WRITE_EN, WRITE_DATA,
    input  READ_DATA, READ_VALID, NACK, BUSY
  );

  modport slave (
    input  DEVICE_ADDR, REG_ADDR, READ_EN, READ_SIZE, WRITE_EN, WRITE_DATA,
    output READ_DATA, READ_VALID, NACK, BUSY
  );

endinterface

// File: rtl/i2c_sensor_sequencer_capture.sv
// Burst-read capture for the sensor sequencer.
// Detects rising edges of the engine's per-byte valid, stores each byte into
// a shadow buffer, and copies the shadow into the output bus on commit so
// downstream logic never sees a partial or failed burst.
// Ports:
//   CLK, RST    clock and synchronous active-high reset
//   clear       restart byte counter (new transaction being set up)
//   capture_en  a read transaction is in flight
//   read_valid  engine byte valid (high for a whole ACK bit period)
//   read_data   engine byte
//   commit      successful burst: publish shadow buffer
//   poll_data   last good burst, byte 0 in the LSBs
//   data_ready  one-cycle pulse coincident with a poll_data update
module i2c_seq_capture #(
  parameter int POLL_SIZE = 14
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   clear,
  input  logic                   capture_en,
  input  logic                   read_valid,
  input  logic [7:0]             read_data,
  input  logic                   commit,
  output logic [POLL_SIZE*8-1:0] poll_data,
  output logic                   data_ready
);

  localparam int BW = $clog2(POLL_SIZE + 1);

  logic                   valid_d;
  logic [BW-1:0]          bcnt;
  logic [POLL_SIZE*8-1:0] shadow;

  // Bytes past POLL_SIZE are dropped rather than wrapping onto byte 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_d <= 1'b0;
      bcnt    <= '0;
      shadow  <= '0;
    end else begin
      valid_d <= read_valid;
      if (clear) begin
        bcnt <= '0;
      end else if (capture_en && read_valid && !valid_d && (bcnt < BW'(POLL_SIZE))) begin
        for (int i = 0; i < POLL_SIZE; i++) begin
          if (bcnt == BW'(i)) shadow[i*8 +: 8] <= read_data;
        end
        bcnt <= bcnt + BW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      poll_data  <= '0;
      data_ready <= 1'b0;
    end else begin
      data_ready <= commit;
      if (commit) poll_data <= shadow;
    end
  end

endmodule

// File: rtl/i2c_sensor_sequencer.sv
// Autonomous sequencer owning the I2C master engine's request interface.
// After ENABLE it writes the configuration table one register per
// transaction, then burst-reads POLL_SIZE bytes from POLL_REG on each TRIG.
// Failed attempts (NACK or start timeout) are retried up to MAX_RETRY times
// and counted; exhausting retries parks the FSM in FAULT.
// Ports:
//   CLK, RST     clock and synchronous active-high reset
//   ENABLE       level: run init then polling; low returns to idle after
//                the current transaction
//   TRIG         single-cycle poll request
//   i2c          master-side request interface to the engine
//   POLL_DATA    last good burst, byte 0 in the LSBs
//   DATA_READY   one-cycle pulse when POLL_DATA updates
//   INIT_DONE    configuration table written; cleared in idle
//   ERROR        sticky fault; cleared in idle
//   OVERRUN      sticky: TRIG while a trigger was already pending
//   NACK_COUNT   saturating count of failed attempts, cleared by RST only
module i2c_sensor_sequencer
  import i2c_seq_pkg::*;
#(
  parameter logic [6:0]            DEV_ADDR      = 7'h68,
  parameter int                    INIT_LEN      = IMU_INIT_LEN,
  parameter logic [INIT_LEN*8-1:0] INIT_REGS     = IMU_INIT_REGS,
  parameter logic [INIT_LEN*8-1:0] INIT_VALS     = IMU_INIT_VALS,
  parameter logic [7:0]            POLL_REG      = 8'h3B,
  parameter int                    POLL_SIZE     = 14,
  parameter int                    MAX_RETRY     = 3,
  parameter int                    START_TIMEOUT = 64,
  parameter int                    GAP           = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   ENABLE,
  input  logic                   TRIG,
  i2c_sensor_sequencer_if.master i2c,
  output logic [POLL_SIZE*8-1:0] POLL_DATA,
  output logic                   DATA_READY,
  output logic                   INIT_DONE,
  output logic                   ERROR,
  output logic                   OVERRUN,
  output logic [7:0]             NACK_COUNT
);

  seq_state_t state, state_nxt;
  seq_op_t    op, op_nxt;
  logic [3:0]  idx, idx_nxt;
  logic [7:0]  retry, retry_nxt;
  logic [15:0] tmo, tmo_nxt;
  logic [15:0] gap_cnt, gap_cnt_nxt;
  logic        failed, failed_nxt;
  logic        pending, pending_nxt;
  logic        overrun, overrun_nxt;
  logic        error, error_nxt;
  logic        init_done, init_done_nxt;
  logic [7:0]  nack_count, nack_count_nxt;
  logic [7:0]  reg_addr, reg_addr_nxt;
  logic [7:0]  write_data, write_data_nxt;
  logic        commit;
  logic        fail_now;
  logic        consume;
  logic        in_flight;

  assign i2c.DEVICE_ADDR = DEV_ADDR;
  assign i2c.READ_SIZE   = 8'(POLL_SIZE);
  assign i2c.REG_ADDR    = reg_addr;
  assign i2c.WRITE_DATA  = write_data;

  // Enables are decoded from the state register, so a reset drops both on
  // the very next edge and only one can ever be high.
  assign in_flight    = (state == ST_ARM) || (state == ST_ACTIVE);
  assign i2c.WRITE_EN = in_flight && (op == OP_WRITE);
  assign i2c.READ_EN  = in_flight && (op == OP_READ);

  assign INIT_DONE  = init_done;
  assign ERROR      = error;
  assign OVERRUN    = overrun;
  assign NACK_COUNT = nack_count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      op         <= OP_WRITE;
      idx        <= '0;
      retry      <= '0;
      tmo        <= '0;
      gap_cnt    <= '0;
      failed     <= 1'b0;
      pending    <= 1'b0;
      overrun    <= 1'b0;
      error      <= 1'b0;
      init_done  <= 1'b0;
      nack_count <= '0;
      reg_addr   <= '0;
      write_data <= '0;
    end else begin
      state      <= state_nxt;
      op         <= op_nxt;
      idx        <= idx_nxt;
      retry      <= retry_nxt;
      tmo        <= tmo_nxt;
      gap_cnt    <= gap_cnt_nxt;
      failed     <= failed_nxt;
      pending    <= pending_nxt;
      overrun    <= overrun_nxt;
      error      <= error_nxt;
      init_done  <= init_done_nxt;
      nack_count <= nack_count_nxt;
      reg_addr   <= reg_addr_nxt;
      write_data <= write_data_nxt;
    end
  end

  // Next-state logic. Dispatch decisions are made on the last GAP cycle.
  // The request registers are loaded on entry to SETUP so they are already
  // valid throughout SETUP, one cycle ahead of the enable rising in ARM.
  always_comb begin
    state_nxt      = state;
    op_nxt         = op;
    idx_nxt        = idx;
    retry_nxt      = retry;
    tmo_nxt        = tmo;
    gap_cnt_nxt    = gap_cnt;
    failed_nxt     = failed;
    pending_nxt    = pending;
    overrun_nxt    = overrun;
    error_nxt      = error;
    init_done_nxt  = init_done;
    nack_count_nxt = nack_count;
    reg_addr_nxt   = reg_addr;
    write_data_nxt = write_data;
    commit         = 1'b0;
    fail_now       = 1'b0;
    consume        = 1'b0;

    case (state)
      ST_IDLE: begin
        init_done_nxt = 1'b0;
        error_nxt     = 1'b0;
        overrun_nxt   = 1'b0;
        pending_nxt   = 1'b0;
        if (ENABLE) begin
          idx_nxt   = '0;
          retry_nxt = '0;
          state_nxt = ST_SETUP;
        end
      end

      ST_SETUP: begin
        tmo_nxt   = '0;
        state_nxt = ST_ARM;
      end

      ST_ARM: begin
        if (i2c.BUSY) begin
          state_nxt = ST_ACTIVE;
        end else if (tmo == 16'(START_TIMEOUT - 1)) begin
          fail_now    = 1'b1;
          failed_nxt  = 1'b1;
          gap_cnt_nxt = '0;
          state_nxt   = ST_GAP;
        end else begin
          tmo_nxt = tmo + 16'd1;
        end
      end

      ST_ACTIVE: begin
        if (!i2c.BUSY) begin
          fail_now    = i2c.NACK;
          failed_nxt  = i2c.NACK;
          gap_cnt_nxt = '0;
          state_nxt   = ST_GAP;
        end
      end

      ST_GAP: begin
        if (gap_cnt == 16'(GAP - 1)) begin
          if (!ENABLE) begin
            state_nxt = ST_IDLE;
          end else if (failed) begin
            if (retry < 8'(MAX_RETRY)) begin
              retry_nxt = retry + 8'd1;
              state_nxt = ST_SETUP;
            end else begin
              state_nxt = ST_FAULT;
            end
          end else if (op == OP_WRITE) begin
            idx_nxt   = idx + 4'd1;
            retry_nxt = '0;
            if (idx + 4'd1 == 4'(INIT_LEN)) begin
              init_done_nxt = 1'b1;
              state_nxt     = ST_WAIT_TRIG;
            end else begin
              state_nxt = ST_SETUP;
            end
          end else begin
            commit    = 1'b1;
            state_nxt = ST_WAIT_TRIG;
          end
        end else begin
          gap_cnt_nxt = gap_cnt + 16'd1;
        end
      end

      ST_WAIT_TRIG: begin
        if (!ENABLE) begin
          state_nxt = ST_IDLE;
        end else if (pending) begin
          consume     = 1'b1;
          pending_nxt = 1'b0;
          retry_nxt   = '0;
          state_nxt   = ST_SETUP;
        end
      end

      ST_FAULT: begin
        error_nxt = 1'b1;
        if (!ENABLE) state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase

    if (fail_now && (nack_count != 8'hFF)) nack_count_nxt = nack_count + 8'd1;

    // A trigger landing on the cycle the flag is consumed simply re-arms it.
    if (TRIG && (state != ST_IDLE) && (state != ST_FAULT)) begin
      if (pending && !consume) overrun_nxt = 1'b1;
      pending_nxt = 1'b1;
    end

    if ((state_nxt == ST_SETUP) && (state != ST_SETUP)) begin
      if (init_done_nxt) begin
        op_nxt         = OP_READ;
        reg_addr_nxt   = POLL_REG;
        write_data_nxt = 8'h00;
      end else begin
        op_nxt         = OP_WRITE;
        reg_addr_nxt   = table_entry(64'(INIT_REGS), idx_nxt);
        write_data_nxt = table_entry(64'(INIT_VALS), idx_nxt);
      end
    end
  end

  i2c_seq_capture #(
    .POLL_SIZE (POLL_SIZE)
  ) u_capture (
    .CLK        (CLK),
    .RST        (RST),
    .clear      (state == ST_SETUP),
    .capture_en (i2c.READ_EN),
    .read_valid (i2c.READ_VALID),
    .read_data  (i2c.READ_DATA),
    .commit     (commit),
    .poll_data  (POLL_DATA),
    .data_ready (DATA_READY)
  );

endmodule

// File: tb/tb_i2c_sensor_sequencer.sv
// Self-checking bench for i2c_sensor_sequencer.
// A behavioural I2C engine/sensor answers each request with random latency
// and random read bytes, logging every attempt; scenarios compare the
// logged transactions and DUT outputs against what the sequencing rules
// require.
module tb_i2c_sensor_sequencer;

  localparam int POLL_SIZE = 14;
  localparam int POLL_BITS = POLL_SIZE * 8;
  localparam int GAP       = 8;
  localparam int TMO       = 64;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic                 ENABLE;
  logic                 TRIG;
  logic [POLL_BITS-1:0] POLL_DATA;
  logic                 DATA_READY;
  logic                 INIT_DONE;
  logic                 ERROR;
  logic                 OVERRUN;
  logic [7:0]           NACK_COUNT;

  i2c_sensor_sequencer_if bus ();

  i2c_sensor_sequencer #(
    .DEV_ADDR      (7'h68),
    .INIT_LEN      (2),
    .INIT_REGS     (16'h1B6B),
    .INIT_VALS     (16'h1800),
    .POLL_REG      (8'h3B),
    .POLL_SIZE     (POLL_SIZE),
    .MAX_RETRY     (3),
    .START_TIMEOUT (TMO),
    .GAP           (GAP)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ENABLE     (ENABLE),
    .TRIG       (TRIG),
    .i2c        (bus.master),
    .POLL_DATA  (POLL_DATA),
    .DATA_READY (DATA_READY),
    .INIT_DONE  (INIT_DONE),
    .ERROR      (ERROR),
    .OVERRUN    (OVERRUN),
    .NACK_COUNT (NACK_COUNT)
  );

  always #5 CLK = ~CLK;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Engine model state and attempt log
  bit                   fail_at [0:255];
  bit                   busy_dead     = 1'b0;
  bit                   fixed_pattern = 1'b0;
  bit                   att_rd   [$];
  logic [7:0]           att_reg  [$];
  logic [7:0]           att_data [$];
  logic [POLL_BITS-1:0] good_polls [$];
  int                   en_drop_err = 0;

  // Bus monitor state
  int en_len [$];
  int dr_count    = 0;
  int gap_viol    = 0;
  int both_en_err = 0;
  int partial_err = 0;

  // Counts one comparison and reports it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drives ENABLE and optionally a one-cycle TRIG pulse.
  task automatic applyStimulus(input logic en, input logic trig);
    @(posedge CLK); #1;
    ENABLE = en;
    TRIG   = trig;
    if (trig) begin
      @(posedge CLK); #1;
      TRIG = 1'b0;
    end
  endtask

  task automatic doReset();
    @(posedge CLK); #1;
    RST = 1'b1; ENABLE = 1'b0; TRIG = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic waitAttempts(input string tag, input int n, input int budget);
    int c = 0;
    while (att_rd.size() < n && c < budget) begin
      @(negedge CLK);
      c++;
    end
    checkOutput(tag, 128'(att_rd.size()), 128'(n));
  endtask

  task automatic waitReady(input string tag, input int n, input int budget);
    int c = 0;
    while (dr_count < n && c < budget) begin
      @(negedge CLK);
      c++;
    end
    checkOutput(tag, 128'(dr_count), 128'(n));
  endtask

  task automatic waitBusyRead(input string tag, input int budget);
    int c = 0;
    while (!(bus.BUSY && bus.READ_EN) && c < budget) begin
      @(negedge CLK);
      c++;
    end
    checkOutput(tag, 128'(bus.BUSY && bus.READ_EN), 128'(1));
  endtask

  task automatic checkAttempt(input string tag, input int i, input bit rd,
                              input logic [7:0] ra, input logic [7:0] wd);
    if (i >= att_rd.size()) begin
      checkOutput({tag, "_present"}, 128'(att_rd.size()), 128'(i + 1));
    end else begin
      checkOutput({tag, "_op"}, 128'(att_rd[i]), 128'(rd));
      checkOutput({tag, "_reg"}, 128'(att_reg[i]), 128'(ra));
      if (!rd) checkOutput({tag, "_data"}, 128'(att_data[i]), 128'(wd));
    end
  endtask

  // One engine cycle while a request is outstanding; its enable must stay up.
  task automatic engineStep(input bit is_rd);
    @(posedge CLK); #1;
    if (!(is_rd ? bus.READ_EN : bus.WRITE_EN)) en_drop_err++;
  endtask

  task automatic serveAttempt();
    bit                   is_rd;
    logic [7:0]           ra, wd, b;
    bit                   f;
    logic [POLL_BITS-1:0] img;
    int                   lat;
    is_rd = bus.READ_EN;
    ra    = bus.REG_ADDR;
    wd    = bus.WRITE_DATA;
    f     = fail_at[att_rd.size()];
    img   = '0;
    lat   = $urandom_range(1, 4);
    repeat (lat) engineStep(is_rd);
    bus.BUSY = 1'b1;
    bus.NACK = 1'b0;
    if (is_rd) begin
      for (int i = 0; i < POLL_SIZE; i++) begin
        b = fixed_pattern ? 8'(i + 1) : 8'($urandom_range(0, 255));
        img[i*8 +: 8]  = b;
        bus.READ_DATA  = b;
        bus.READ_VALID = 1'b1;
        repeat (2) engineStep(is_rd);
        bus.READ_VALID = 1'b0;
        repeat (2) engineStep(is_rd);
      end
    end else begin
      lat = $urandom_range(3, 8);
      repeat (lat) engineStep(is_rd);
    end
    bus.BUSY = 1'b0;
    bus.NACK = f;
    att_rd.push_back(is_rd);
    att_reg.push_back(ra);
    att_data.push_back(wd);
    if (is_rd && !f) good_polls.push_back(img);
  endtask

  initial begin : engine_model
    bus.BUSY = 1'b0; bus.NACK = 1'b0; bus.READ_VALID = 1'b0; bus.READ_DATA = 8'h00;
    forever begin
      @(posedge CLK); #1;
      if (RST) begin
        bus.BUSY = 1'b0; bus.NACK = 1'b0; bus.READ_VALID = 1'b0;
      end else if (!busy_dead && (bus.WRITE_EN || bus.READ_EN)) begin
        serveAttempt();
      end
    end
  end

  always @(negedge CLK) begin : bus_monitor
    logic en_now;
    static logic                 prev_en = 1'b0;
    static int                   low_cnt = 0;
    static int                   hi_cnt  = 0;
    static bit                   seen    = 1'b0;
    static logic [POLL_BITS-1:0] prev_poll = '0;
    en_now = bus.WRITE_EN | bus.READ_EN;
    if (bus.WRITE_EN && bus.READ_EN) both_en_err++;
    if (RST) begin
      prev_en = 1'b0; low_cnt = 0; hi_cnt = 0; seen = 1'b0; prev_poll = POLL_DATA;
    end else begin
      if (en_now && !prev_en && seen && low_cnt < GAP) gap_viol++;
      if (en_now) begin
        hi_cnt++; low_cnt = 0; seen = 1'b1;
      end else begin
        if (prev_en) en_len.push_back(hi_cnt);
        hi_cnt = 0; low_cnt++;
      end
      if (DATA_READY) dr_count++;
      if (POLL_DATA != prev_poll && !DATA_READY) partial_err++;
      prev_poll = POLL_DATA;
      prev_en   = en_now;
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int                   base, d0, l0;
    logic [POLL_BITS-1:0] exp_poll, keep_poll;
    RST = 1'b1; ENABLE = 1'b0; TRIG = 1'b0;

    // ---- Reset state
    doReset();
    @(negedge CLK);
    checkOutput("rst_dev_addr", 128'(bus.DEVICE_ADDR), 128'(7'h68));
    checkOutput("rst_read_size", 128'(bus.READ_SIZE), 128'(POLL_SIZE));
    checkOutput("rst_enables", 128'({bus.WRITE_EN, bus.READ_EN}), 128'(0));
    checkOutput("rst_reg_addr", 128'(bus.REG_ADDR), 128'(0));
    checkOutput("rst_poll_data", 128'(POLL_DATA), 128'(0));
    checkOutput("rst_flags", 128'({DATA_READY, INIT_DONE, ERROR, OVERRUN}), 128'(0));
    checkOutput("rst_nack_count", 128'(NACK_COUNT), 128'(0));

    // ---- Init and poll with a well-behaved sensor
    base = att_rd.size();
    fixed_pattern = 1'b1;
    applyStimulus(1'b1, 1'b0);
    waitAttempts("init_writes", base + 2, 400);
    repeat (GAP + 6) @(negedge CLK);
    checkAttempt("init_w0", base, 1'b0, 8'h6B, 8'h00);
    checkAttempt("init_w1", base + 1, 1'b0, 8'h1B, 8'h18);
    checkOutput("init_done", 128'(INIT_DONE), 128'(1));
    d0 = dr_count;
    applyStimulus(1'b1, 1'b1);
    waitReady("poll_ready", d0 + 1, 600);
    checkAttempt("poll_rd", base + 2, 1'b1, 8'h3B, 8'h00);
    checkOutput("poll_byte0", 128'(POLL_DATA[7:0]), 128'(8'h01));
    checkOutput("poll_byte13", 128'(POLL_DATA[111:104]), 128'(8'h0E));
    for (int i = 0; i < POLL_SIZE; i++) exp_poll[i*8 +: 8] = 8'(i + 1);
    checkOutput("poll_all", 128'(POLL_DATA), 128'(exp_poll));
    repeat (30) @(negedge CLK);
    checkOutput("poll_one_pulse", 128'(dr_count), 128'(d0 + 1));
    fixed_pattern = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d0 = dr_count;
      applyStimulus(1'b1, 1'b1);
      waitReady("rand_poll_ready", d0 + 1, 600);
      checkOutput("rand_poll_data", 128'(POLL_DATA), 128'(good_polls[good_polls.size() - 1]));
    end
    checkOutput("poll_nack_count", 128'(NACK_COUNT), 128'(0));

    // ---- NACK on the first attempt of write 1, TRIG held during init
    doReset();
    base = att_rd.size();
    fail_at[base + 1] = 1'b1;
    d0 = dr_count;
    applyStimulus(1'b1, 1'b0);
    repeat (3) @(posedge CLK);
    applyStimulus(1'b1, 1'b1);
    waitAttempts("retry_attempts", base + 3, 600);
    repeat (GAP + 6) @(negedge CLK);
    checkAttempt("retry_w1a", base + 1, 1'b0, 8'h1B, 8'h18);
    checkAttempt("retry_w1b", base + 2, 1'b0, 8'h1B, 8'h18);
    checkOutput("retry_nack_count", 128'(NACK_COUNT), 128'(1));
    checkOutput("retry_init_done", 128'(INIT_DONE), 128'(1));
    checkOutput("retry_error", 128'(ERROR), 128'(0));
    waitReady("held_trig_ready", d0 + 1, 600);
    checkAttempt("held_trig_rd", base + 3, 1'b1, 8'h3B, 8'h00);
    checkOutput("held_trig_overrun", 128'(OVERRUN), 128'(0));

    // ---- Every attempt of write 0 NACKed: fault after 4 attempts
    doReset();
    base = att_rd.size();
    for (int k = 0; k < 4; k++) fail_at[base + k] = 1'b1;
    d0 = dr_count;
    applyStimulus(1'b1, 1'b0);
    waitAttempts("fault_attempts", base + 4, 800);
    repeat (GAP + 6) @(negedge CLK);
    for (int k = 0; k < 4; k++) checkAttempt("fault_w0", base + k, 1'b0, 8'h6B, 8'h00);
    checkOutput("fault_error", 128'(ERROR), 128'(1));
    checkOutput("fault_nack_count", 128'(NACK_COUNT), 128'(4));
    checkOutput("fault_init_done", 128'(INIT_DONE), 128'(0));
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    repeat (100) @(negedge CLK);
    checkOutput("fault_no_more", 128'(att_rd.size()), 128'(base + 4));
    checkOutput("fault_no_ready", 128'(dr_count), 128'(d0));
    checkOutput("fault_trig_ignored", 128'(OVERRUN), 128'(0));
    applyStimulus(1'b0, 1'b0);
    repeat (4) @(negedge CLK);
    checkOutput("fault_cleared", 128'(ERROR), 128'(0));
    checkOutput("fault_count_kept", 128'(NACK_COUNT), 128'(4));

    // ---- Start timeout: engine never goes busy
    doReset();
    busy_dead = 1'b1;
    l0 = en_len.size();
    applyStimulus(1'b1, 1'b0);
    begin
      int c = 0;
      while (en_len.size() < l0 + 4 && c < 800) begin
        @(negedge CLK);
        c++;
      end
    end
    checkOutput("tmo_attempts", 128'(en_len.size()), 128'(l0 + 4));
    for (int k = 0; k < 4 && l0 + k < en_len.size(); k++)
      checkOutput("tmo_enable_len", 128'(en_len[l0 + k]), 128'(TMO));
    repeat (GAP + 6) @(negedge CLK);
    checkOutput("tmo_error", 128'(ERROR), 128'(1));
    checkOutput("tmo_nack_count", 128'(NACK_COUNT), 128'(4));
    applyStimulus(1'b0, 1'b0);
    repeat (4) @(posedge CLK);
    busy_dead = 1'b0;

    // ---- Overrun during an active read, then a read that fails outright
    doReset();
    base = att_rd.size();
    applyStimulus(1'b1, 1'b0);
    waitAttempts("ovr_init", base + 2, 400);
    repeat (GAP + 6) @(negedge CLK);
    d0 = dr_count;
    applyStimulus(1'b1, 1'b1);
    waitBusyRead("ovr_busy", 100);
    applyStimulus(1'b1, 1'b1);
    @(posedge CLK);
    applyStimulus(1'b1, 1'b1);
    checkOutput("ovr_flag", 128'(OVERRUN), 128'(1));
    waitReady("ovr_two_reads", d0 + 2, 1200);
    repeat (150) @(negedge CLK);
    checkOutput("ovr_exactly_one_extra", 128'(dr_count), 128'(d0 + 2));
    checkOutput("ovr_attempts", 128'(att_rd.size()), 128'(base + 4));
    checkOutput("ovr_poll_data", 128'(POLL_DATA), 128'(good_polls[good_polls.size() - 1]));
    keep_poll = POLL_DATA;
    base = att_rd.size();
    for (int k = 0; k < 4; k++) fail_at[base + k] = 1'b1;
    d0 = dr_count;
    applyStimulus(1'b1, 1'b1);
    waitAttempts("badrd_attempts", base + 4, 1500);
    repeat (GAP + 6) @(negedge CLK);
    checkOutput("badrd_poll_kept", 128'(POLL_DATA), 128'(keep_poll));
    checkOutput("badrd_no_ready", 128'(dr_count), 128'(d0));
    checkOutput("badrd_error", 128'(ERROR), 128'(1));
    checkOutput("badrd_nack_count", 128'(NACK_COUNT), 128'(4));
    applyStimulus(1'b0, 1'b0);

    // ---- ENABLE dropped while a read is busy, then re-enable
    doReset();
    base = att_rd.size();
    applyStimulus(1'b1, 1'b0);
    waitAttempts("dis_init", base + 2, 400);
    repeat (GAP + 6) @(negedge CLK);
    applyStimulus(1'b1, 1'b1);
    waitBusyRead("dis_busy", 100);
    applyStimulus(1'b0, 1'b0);
    waitAttempts("dis_read_done", base + 3, 400);
    repeat (60) @(negedge CLK);
    checkOutput("dis_init_done", 128'(INIT_DONE), 128'(0));
    checkOutput("dis_idle", 128'(att_rd.size()), 128'(base + 3));
    applyStimulus(1'b1, 1'b0);
    waitAttempts("reen_writes", base + 5, 400);
    repeat (GAP + 6) @(negedge CLK);
    checkAttempt("reen_w0", base + 3, 1'b0, 8'h6B, 8'h00);
    checkAttempt("reen_w1", base + 4, 1'b0, 8'h1B, 8'h18);
    checkOutput("reen_init_done", 128'(INIT_DONE), 128'(1));

    // ---- Bus-level invariants over the whole run
    checkOutput("enable_held_while_busy", 128'(en_drop_err), 128'(0));
    checkOutput("min_gap", 128'(gap_viol), 128'(0));
    checkOutput("one_enable", 128'(both_en_err), 128'(0));
    checkOutput("atomic_poll", 128'(partial_err), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
